mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the core's instruction-fetch and data-access requesters onto one single-port synchronous memory, so the core can run against a single-ported memory instead of the dual-port memory. Sits between the core's imem/dmem native memory ports and the memory macro. Issues at most one memory command per cycle and routes the one-cycle-latency read data back to the requester that issued the read. By default, data accesses win conflicts. An optional starvation guard bounds instruction-fetch wait time.

## Interface
Parameters:
- ADDR_W, 32: byte-address width of both requester ports.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.
- STARVE_MAX, 4: consecutive denied imem cycles before imem is forced to win. Range 1..15; 4-bit counter. Used only with the guard macro.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- imem_req  in  1  fetch request; held with imem_addr until imem_gnt.
- imem_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- imem_gnt  out  1  request accepted this cycle (combinational).
- imem_rvalid  out  1  imem_rdata valid.
- imem_rdata  out  DATA_W  fetch data.
- dmem_req  in  1  data request; held with all dmem_* inputs until dmem_gnt.
- dmem_we  in  1  1 = write, 0 = read.
- dmem_addr  in  ADDR_W  data byte address; bits [1:0] ignored.
- dmem_wdata  in  DATA_W  write data.
- dmem_be  in  DATA_W/8  write byte enables.
- dmem_gnt  out  1  request accepted this cycle (combinational).
- dmem_rvalid  out  1  dmem_rdata valid; reads only.
- dmem_rdata  out  DATA_W  read data.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W-2  word address, equal to byte address >> 2.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables; all-ones on reads.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_re.

## Operation
- Each cycle the arbiter selects one winner among the asserted requests.
  - Default priority is dmem over imem.
  - At most one of imem_gnt and dmem_gnt is high in any cycle.
- The winner's command drives mem_* combinationally in the grant cycle:
  - imem wins: mem_re=1, mem_we=0.
  - dmem read wins: mem_re=1, mem_we=0.
  - dmem write wins: mem_we=1, mem_re=0.
- With no winner, mem_re and mem_we are 0. mem_addr, mem_wdata and mem_be then hold their last driven values.
- Read-owner register rd_own (states NONE, IMEM, DMEM):
  - Loaded in each grant cycle with the owner of that cycle's read, or NONE for a write or no grant.
  - Next cycle, the owner's rvalid=1 and its rdata=mem_rdata. The other port's rvalid=0.
- Each port's rdata holds its last value when that port's rvalid is 0.
- A grant issued during a cycle in which the previous read's data returns is legal, giving back-to-back throughput of 1 access per cycle.
- A dmem write followed immediately by a read to the same address returns the new data; memory write-first ordering is relied on.

## Timing
- Grant latency is 0 cycles when uncontested. Read latency from grant to rvalid is exactly 1 cycle. A write completes in its grant cycle.
- While rst=1:
  - All gnt, rvalid, mem_re and mem_we outputs are 0.
  - rdata outputs, mem_addr, mem_wdata and mem_be are 0.
  - rd_own is NONE and the starvation counter is 0.
- Reset asserted while a read is pending: the pending rvalid is dropped and never delivered.
- Simultaneous imem and dmem requests: dmem is granted and imem waits, unless the starvation guard forces imem.
- A requester that drops req before receiving gnt is a protocol violation and needs no defined behaviour. The arbiter holds no request state across cycles apart from the counter.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments in each cycle where imem_req=1 and imem_gnt=0, saturating at STARVE_MAX.
  - While the counter equals STARVE_MAX, imem has priority over dmem.
  - The counter clears to 0 on an imem grant or when imem_req=0.
- MEM_ARB_STARVE_GUARD_EN undefined: strict dmem priority; no counter is instantiated.

## Test plan
- Reset: hold rst=1 for 3 cycles with both requests asserted -> all gnt, rvalid and mem strobes are 0; after release, dmem_gnt=1 in the first cycle.
- imem only: read addr 0x0000_0010 with memory word 4 = 0xDEAD_BEEF -> imem_gnt in cycle 0 with mem_addr=4; imem_rvalid=1 and imem_rdata=0xDEAD_BEEF in cycle 1.
- Contention: both request reads in cycle 0 (dmem addr 0x20) -> cycle 0 dmem_gnt; cycle 1 imem_gnt and dmem_rvalid; cycle 2 imem_rvalid.
- Write then read: dmem write 0x1234_5678, be=4'b0011 to 0x40 over old data 0xFFFF_FFFF, then read 0x40 -> mem_we with mem_be=4'b0011, then read returns 0xFFFF_5678.
- Starvation, with the macro defined and STARVE_MAX=4: dmem_req held high continuously alongside imem_req -> imem_gnt in cycle 4 exactly. Without the macro, imem_gnt stays 0 while dmem_req stays high.
- Reset mid-read: assert rst in the cycle after an imem grant -> imem_rvalid stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates imem fetches and dmem accesses onto one single-port synchronous memory.
// Define MEM_ARB_STARVE_GUARD_EN to bound how long imem can be denied by dmem.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                imem_req_i,
  input  logic [ADDR_W-1:0]   imem_addr_i,
  output logic                imem_gnt_o,
  output logic                imem_rvalid_o,
  output logic [DATA_W-1:0]   imem_rdata_o,
  input  logic                dmem_req_i,
  input  logic                dmem_we_i,
  input  logic [ADDR_W-1:0]   dmem_addr_i,
  input  logic [DATA_W-1:0]   dmem_wdata_i,
  input  logic [DATA_W/8-1:0] dmem_be_i,
  output logic                dmem_gnt_o,
  output logic                dmem_rvalid_o,
  output logic [DATA_W-1:0]   dmem_rdata_o,
  output logic                mem_re_o,
  output logic                mem_we_o,
  output logic [ADDR_W-3:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IMEM,
    OWN_DMEM
  } rd_own_e;

  rd_own_e           rd_own_q, rd_own_d;
  logic              imem_win, dmem_win, imem_force;
  logic              mem_re, mem_we;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] imem_rdata_q, imem_rdata_d;
  logic [DATA_W-1:0] dmem_rdata_q, dmem_rdata_d;
  logic              imem_rvalid, dmem_rvalid;

  // Byte-offset bits never reach the word-addressed memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_addr_i[1:0], dmem_addr_i[1:0]};

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  assign imem_force = (starve_q == 4'(STARVE_MAX));

  always_comb begin
    starve_d = 4'd0;
    if (imem_req_i && !imem_win) begin
      starve_d = imem_force ? starve_q : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX == 0);
  assign imem_force        = 1'b0;
`endif

  // Command address, data and enables hold their last values on idle cycles.
  always_comb begin
    imem_win    = 1'b0;
    dmem_win    = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    rd_own_d    = OWN_NONE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if (rst_i) begin
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      mem_be_d    = '0;
    end else if (imem_req_i && (!dmem_req_i || imem_force)) begin
      imem_win   = 1'b1;
      mem_re     = 1'b1;
      rd_own_d   = OWN_IMEM;
      mem_addr_d = imem_addr_i[ADDR_W-1:2];
      mem_be_d   = '1;
    end else if (dmem_req_i) begin
      dmem_win   = 1'b1;
      mem_addr_d = dmem_addr_i[ADDR_W-1:2];
      if (dmem_we_i) begin
        mem_we      = 1'b1;
        mem_wdata_d = dmem_wdata_i;
        mem_be_d    = dmem_be_i;
      end else begin
        mem_re   = 1'b1;
        rd_own_d = OWN_DMEM;
        mem_be_d = '1;
      end
    end
  end

  assign imem_rvalid  = !rst_i && (rd_own_q == OWN_IMEM);
  assign dmem_rvalid  = !rst_i && (rd_own_q == OWN_DMEM);
  assign imem_rdata_d = rst_i ? '0 : (imem_rvalid ? mem_rdata_i : imem_rdata_q);
  assign dmem_rdata_d = rst_i ? '0 : (dmem_rvalid ? mem_rdata_i : dmem_rdata_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_own_q     <= OWN_NONE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
    end else begin
      rd_own_q     <= rd_own_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
    end
  end

  assign imem_gnt_o    = imem_win;
  assign dmem_gnt_o    = dmem_win;
  assign imem_rvalid_o = imem_rvalid;
  assign dmem_rvalid_o = dmem_rvalid;
  assign imem_rdata_o  = imem_rdata_d;
  assign dmem_rdata_o  = dmem_rdata_d;
  assign mem_re_o      = mem_re;
  assign mem_we_o      = mem_we;
  assign mem_addr_o    = mem_addr_d;
  assign mem_wdata_o   = mem_wdata_d;
  assign mem_be_o      = mem_be_d;

endmodule
